dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer sharing the single-port data memory between port 0 (core LSU) and port 1 (debug/DMA).

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sharing a single-port data memory between core LSU (p0) and debug/DMA (p1).
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make p0 always win ties (p1 may starve); default is round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [1:0]        p0_we,
    input  logic [2:0]        p0_re,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [1:0]        p1_we,
    input  logic [2:0]        p1_re,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        mem_we,
    output logic [2:0]        mem_re,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic [1:0]        we_q;
    logic [2:0]        re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              sel;
    logic              take;
    logic              in_range;
    logic [31:0]       load_data;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              rr_last;
`endif

    // Arbitration: pick p1 only when it alone requests or it is p1's turn; never grant while in ACC or in reset.
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        sel = p1_req && !p0_req;
`else
        sel = p1_req && (!p0_req || !rr_last);
`endif
        take      = rst && (state != ACC) && (p0_req || p1_req);
        in_range  = addr_q < ADDR_W'(DEPTH);
        load_data = (we_q == 2'b00 && in_range) ? mem_rd : 32'h0;
    end

    assign p0_gnt    = take && !sel;
    assign p1_gnt    = take && sel;
    assign p0_rvalid = (state == RESP) && !owner;
    assign p1_rvalid = (state == RESP) && owner;
    assign mem_a     = addr_q;
    assign mem_re    = re_q;
    assign mem_wd    = wdata_q;
    assign mem_we    = (state == ACC && in_range) ? we_q : 2'b00;

    // Sequencer: latch the winning request on grant and step IDLE -> ACC -> RESP -> (ACC | IDLE).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            we_q    <= 2'b00;
            re_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_last <= 1'b1;
`endif
        end else begin
            if (take) begin
                owner   <= sel;
                we_q    <= sel ? p1_we    : p0_we;
                re_q    <= sel ? p1_re    : p0_re;
                addr_q  <= sel ? p1_addr  : p0_addr;
                wdata_q <= sel ? p1_wdata : p0_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                rr_last <= sel;
`endif
            end
            state <= (state == ACC) ? RESP : (take ? ACC : IDLE);
        end
    end

    // Response capture: at the end of ACC store the load result and range error into the owner's output regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_rdata <= 32'h0;
            p0_err   <= 1'b0;
            p1_rdata <= 32'h0;
            p1_err   <= 1'b0;
        end else if (state == ACC) begin
            if (owner) begin
                p1_rdata <= load_data;
                p1_err   <= !in_range;
            end else begin
                p0_rdata <= load_data;
                p0_err   <= !in_range;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and hand sequences for the data-memory arbiter.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic [1:0]  p0_we = 2'b00, p1_we = 2'b00;
    logic [2:0]  p0_re = 3'b000, p1_re = 3'b000;
    logic [31:0] p0_addr = 32'h0, p1_addr = 32'h0;
    logic [31:0] p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  mem_we;
    logic [2:0]  mem_re;
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] word;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;
        logic [1:0]  we;
        logic [2:0]  re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vecs [12];

    dmem_arbiter #(.ADDR_W(32), .DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_re(p0_re), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_re(p1_re), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_re(mem_re), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always_comb begin
        word   = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'h0;
        mem_rd = word;
        case (mem_re)
            3'b001:  mem_rd = {{24{word[7]}}, word[7:0]};
            3'b010:  mem_rd = {{16{word[15]}}, word[15:0]};
            3'b011:  mem_rd = {24'h0, word[7:0]};
            3'b100:  mem_rd = {16'h0, word[15:0]};
            default: mem_rd = word;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we != 2'b00 && mem_a < 32'd256) begin
            case (mem_we)
                2'b01:   mem[mem_a[7:0]][7:0]  <= mem_wd[7:0];
                2'b10:   mem[mem_a[7:0]][15:0] <= mem_wd[15:0];
                default: mem[mem_a[7:0]]       <= mem_wd;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_port(input logic port, input logic req, input logic [1:0] we, input logic [2:0] re,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_re = re; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_re = re; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic access(input vec_t v);
        int n;
        @(negedge clk);
        set_port(v.port, 1'b1, v.we, v.re, v.addr, v.wdata);
        #1;
        n = 0;
        while (!(v.port ? p1_gnt : p0_gnt) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("gnt", {31'h0, v.port ? p1_gnt : p0_gnt}, 32'h1);
        chk("other_gnt", {31'h0, v.port ? p0_gnt : p1_gnt}, 32'h0);
        @(negedge clk);
        if (v.port) p1_req = 1'b0; else p0_req = 1'b0;
        #1;
        chk("acc_mem_we", {30'h0, mem_we}, (v.addr < 32'd256) ? {30'h0, v.we} : 32'h0);
        chk("acc_mem_a", mem_a, v.addr);
        chk("acc_no_rvalid", {31'h0, p0_rvalid | p1_rvalid}, 32'h0);
        @(negedge clk);
        #1;
        chk("rvalid", {31'h0, v.port ? p1_rvalid : p0_rvalid}, 32'h1);
        chk("other_rvalid", {31'h0, v.port ? p0_rvalid : p1_rvalid}, 32'h0);
        chk("rdata", v.port ? p1_rdata : p0_rdata, v.rdata);
        chk("err", {31'h0, v.port ? p1_err : p0_err}, {31'h0, v.err});
        chk("resp_mem_we", {30'h0, mem_we}, 32'h0);
        @(negedge clk);
        #1;
        chk("rvalid_pulse", {31'h0, v.port ? p1_rvalid : p0_rvalid}, 32'h0);
        chk("rdata_hold", v.port ? p1_rdata : p0_rdata, v.rdata);
    endtask

    initial begin
        logic e_g0, e_g1, e_v0, e_v1;
        vecs[0]  = '{1'b0, 2'b11, 3'b000, 32'h4,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b00, 3'b000, 32'h4,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 3'b000, 32'h8,   32'h12345680, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'b00, 3'b001, 32'h8,   32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 3'b011, 32'h8,   32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 3'b000, 32'hA,   32'h5555ABCD, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 2'b00, 3'b010, 32'hA,   32'h0,        32'hFFFFABCD, 1'b0};
        vecs[7]  = '{1'b1, 2'b00, 3'b100, 32'hA,   32'h0,        32'h0000ABCD, 1'b0};
        vecs[8]  = '{1'b1, 2'b00, 3'b000, 32'h100, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 2'b11, 3'b000, 32'h100, 32'h11112222, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 2'b00, 3'b000, 32'hFF,  32'h0,        32'h0,        1'b0};
        vecs[11] = '{1'b1, 2'b00, 3'b000, 32'h8,   32'h0,        32'h00000080, 1'b0};

        // reset state, both ports already requesting
        set_port(1'b0, 1'b1, 2'b00, 3'b000, 32'h4, 32'h0);
        set_port(1'b1, 1'b1, 2'b00, 3'b000, 32'h8, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {30'h0, p0_gnt, p1_gnt}, 32'h0);
        chk("rst_rvalid", {30'h0, p0_rvalid, p1_rvalid}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_we", {30'h0, mem_we}, 32'h0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);

        // continuous requests from reset
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            e_g0 = (c % 2 == 0);
            e_g1 = 1'b0;
            e_v0 = (c >= 2) && (c % 2 == 0);
            e_v1 = 1'b0;
`else
            e_g0 = (c % 4 == 0);
            e_g1 = (c % 4 == 2);
            e_v0 = (c >= 2) && (c % 4 == 2);
            e_v1 = (c >= 4) && (c % 4 == 0);
`endif
            chk($sformatf("arb_gnt_c%0d", c), {30'h0, p0_gnt, p1_gnt}, {30'h0, e_g0, e_g1});
            chk($sformatf("arb_rvalid_c%0d", c), {30'h0, p0_rvalid, p1_rvalid}, {30'h0, e_v0, e_v1});
            @(negedge clk);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) access(vecs[i]);
        chk("mem_oob_untouched", mem[8'h00], 32'h0);

        // p1 request abandoned while p0 busy
        @(negedge clk);
        set_port(1'b0, 1'b1, 2'b00, 3'b000, 32'h4, 32'h0);
        #1;
        chk("drop_p0_gnt", {31'h0, p0_gnt}, 32'h1);
        @(negedge clk);
        p0_req = 1'b0;
        set_port(1'b1, 1'b1, 2'b11, 3'b000, 32'h1E, 32'hCAFEF00D);
        #1;
        chk("drop_p1_no_gnt_acc", {31'h0, p1_gnt}, 32'h0);
        #2;
        p1_req = 1'b0;
        @(negedge clk);
        #1;
        chk("drop_p0_rvalid", {31'h0, p0_rvalid}, 32'h1);
        chk("drop_p0_rdata", p0_rdata, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            chk("drop_quiet", {29'h0, p1_gnt, p1_rvalid, |mem_we}, 32'h0);
            @(negedge clk);
            #1;
        end
        chk("drop_mem30", mem[8'h1E], 32'h0);

        // reset during the ACC cycle of a p0 store
        @(negedge clk);
        set_port(1'b0, 1'b1, 2'b11, 3'b000, 32'h14, 32'h00000055);
        #1;
        chk("rstacc_gnt", {31'h0, p0_gnt}, 32'h1);
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        chk("rstacc_we_before", {30'h0, mem_we}, 32'h3);
        rst = 1'b0;
        #1;
        chk("rstacc_ctl", {26'h0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 32'h0);
        chk("rstacc_rdata", p0_rdata | p1_rdata, 32'h0);
        chk("rstacc_mem", mem_a | mem_wd | {29'h0, mem_re} | {30'h0, mem_we}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rstacc_no_rvalid", {31'h0, p0_rvalid}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        set_port(1'b1, 1'b1, 2'b00, 3'b000, 32'h4, 32'h0);
        #1;
        chk("rstacc_p1_gnt", {31'h0, p1_gnt}, 32'h1);
        @(negedge clk);
        p1_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rstacc_p1_rvalid", {30'h0, p0_rvalid, p1_rvalid}, 32'h1);
        chk("rstacc_p1_rdata", p1_rdata, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
